// File: rtl/rf_ctrl_pkg.sv
// Shared constants and types for the register-file access controller.
// Geometry of the 16x16 file, controller states and the default sink register.
package rf_ctrl_pkg;

    localparam int RF_AW        = 4;
    localparam int RF_DW        = 16;
    localparam int RF_NREGS     = 16;
    localparam int SINK_REG_DEF = 15;

    typedef enum logic [1:0] {
        RUN,
        CLR,
        DONE
    } state_t;

endpackage

// File: rtl/rf_access_ctrl_arb.sv
// N-way round-robin arbiter with enable.
// The pointer names the highest-priority requester; it advances past each grant.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [N-1:0] i_req,
    input  logic         i_en,
    output logic [N-1:0] o_gnt
);

    logic [1:0] r_ptr;
    logic [1:0] w_nxt;
    logic [2:0] w_best;

    // Distance of requester j above the pointer, with wrap.
    function automatic logic [2:0] f_dist(input int j, input logic [1:0] p);
        int d;
        d = j - int'(p);
        if (d < 0) d = d + N;
        return 3'(d);
    endfunction

    // Pick the requesting index closest above the pointer.
    always_comb begin
        o_gnt  = '0;
        w_nxt  = r_ptr;
        w_best = 3'd4;
        for (int j = 0; j < N; j++) begin
            if (i_en && i_req[j] && (f_dist(j, r_ptr) < w_best)) begin
                w_best   = f_dist(j, r_ptr);
                o_gnt    = '0;
                o_gnt[j] = 1'b1;
                w_nxt    = (j == N - 1) ? 2'd0 : 2'(j + 1);
            end
        end
    end

    // Pointer moves only when something is granted.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ptr <= 2'd0;
        end else if (|o_gnt) begin
            r_ptr <= w_nxt;
        end
    end

endmodule

// File: rtl/rf_access_ctrl.sv
// Shares a 16x16 register file between N_REQ requesters, one transfer per clock.
// Runs the file's clear sequence after reset and on ClearReq.
module rf_access_ctrl
    import rf_ctrl_pkg::*;
#(
    parameter int N_REQ    = 2,
    parameter int SINK_REG = SINK_REG_DEF
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic [N_REQ-1:0]       ReqValid,
    output logic [N_REQ-1:0]       ReqReady,
    input  logic [4*N_REQ-1:0]     ReqAaddr,
    input  logic [4*N_REQ-1:0]     ReqBaddr,
    input  logic [4*N_REQ-1:0]     ReqCaddr,
    input  logic [N_REQ-1:0]       ReqWrEn,
    input  logic [16*N_REQ-1:0]    ReqC,
    output logic [N_REQ-1:0]       RspValid,
    output logic [RF_DW-1:0]       RspA,
    output logic [RF_DW-1:0]       RspB,
    input  logic                   ClearReq,
    output logic                   ClearDone,
    output logic [RF_AW-1:0]       RF_Aaddr,
    output logic [RF_AW-1:0]       RF_Baddr,
    output logic [RF_AW-1:0]       RF_Caddr,
    output logic [RF_DW-1:0]       RF_C,
    output logic                   RF_Load,
    output logic                   RF_Clear,
    input  logic [RF_DW-1:0]       RF_A,
    input  logic [RF_DW-1:0]       RF_B
);

    localparam logic [RF_AW-1:0] SINK_A = RF_AW'(SINK_REG);

    state_t             r_state;
    logic [N_REQ-1:0]   w_gnt;
    logic [N_REQ-1:0]   r_tag1;
    logic [N_REQ-1:0]   r_tag2;
    logic               w_en;
    logic [RF_AW-1:0]   w_aaddr;
    logic [RF_AW-1:0]   w_baddr;
    logic [RF_AW-1:0]   w_caddr;
    logic [RF_DW-1:0]   w_c;
    logic               w_we;

    // ClearReq wins over any request in the same cycle.
    assign w_en = (r_state == RUN) && !ClearReq;

    rr_arbiter #(
        .N(N_REQ)
    ) u_arb (
        .i_clk(Clk),
        .i_rst(Reset),
        .i_req(ReqValid),
        .i_en (w_en),
        .o_gnt(w_gnt)
    );

    assign ReqReady = w_gnt;
    assign RspValid = r_tag2;
    assign RspA     = RF_A;
    assign RspB     = RF_B;

    // Select the granted requester's transaction fields.
    always_comb begin
        w_aaddr = '0;
        w_baddr = '0;
        w_caddr = '0;
        w_c     = '0;
        w_we    = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_gnt[i]) begin
                w_aaddr = ReqAaddr[RF_AW*i +: RF_AW];
                w_baddr = ReqBaddr[RF_AW*i +: RF_AW];
                w_caddr = ReqCaddr[RF_AW*i +: RF_AW];
                w_c     = ReqC[RF_DW*i +: RF_DW];
                w_we    = ReqWrEn[i];
            end
        end
    end

    // Clear sequencing and registered file-side outputs.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state   <= CLR;
            RF_Aaddr  <= '0;
            RF_Baddr  <= '0;
            RF_Caddr  <= '0;
            RF_C      <= '0;
            RF_Load   <= 1'b0;
            RF_Clear  <= 1'b0;
            ClearDone <= 1'b0;
        end else begin
            ClearDone <= 1'b0;
            RF_Load   <= |w_gnt;
            if (|w_gnt) begin
                RF_Aaddr <= w_aaddr;
                RF_Baddr <= w_baddr;
                RF_Caddr <= w_we ? w_caddr : SINK_A;
                RF_C     <= w_we ? w_c : '0;
            end
            unique case (r_state)
                CLR: begin
                    r_state   <= DONE;
                    RF_Clear  <= 1'b1;
                    ClearDone <= 1'b1;
                end
                DONE: begin
                    r_state <= RUN;
                end
                RUN: begin
                    if (ClearReq) begin
                        r_state  <= CLR;
                        RF_Clear <= 1'b0;
                    end
                end
                default: begin
                    r_state <= CLR;
                end
            endcase
        end
    end

    // Two-stage tag pipeline: response strobe two cycles after grant.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_tag1 <= '0;
            r_tag2 <= '0;
        end else begin
            r_tag1 <= w_gnt;
            r_tag2 <= r_tag1;
        end
    end

endmodule

// File: tb/tb_rf_access_ctrl.sv
// Scoreboard bench for rf_access_ctrl with a behavioural 16x16 register file.
// Expected read data is hand-computed per directed transaction.
module tb_rf_access_ctrl;
    import rf_ctrl_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [1:0]  ReqReady, RspValid;
    logic [15:0] RspA, RspB;
    logic        ClearReq, ClearDone;
    logic [3:0]  RF_Aaddr, RF_Baddr, RF_Caddr;
    logic [15:0] RF_C, RF_A, RF_B;
    logic        RF_Load, RF_Clear;

    logic [1:0]  v, we;
    logic [3:0]  ta[2], tb[2], tc[2];
    logic [15:0] td[2], ea[2], eb[2];
    logic [15:0] mem[16];

    typedef struct {
        int          idx;
        logic [15:0] a;
        logic [15:0] b;
    } exp_t;
    exp_t q[$];

    int errors = 0;
    int checks = 0;

    always #5 Clk = ~Clk;

    rf_access_ctrl #(.N_REQ(2), .SINK_REG(15)) dut (
        .Clk(Clk), .Reset(Reset),
        .ReqValid(v), .ReqReady(ReqReady),
        .ReqAaddr({ta[1], ta[0]}), .ReqBaddr({tb[1], tb[0]}),
        .ReqCaddr({tc[1], tc[0]}), .ReqWrEn(we),
        .ReqC({td[1], td[0]}),
        .RspValid(RspValid), .RspA(RspA), .RspB(RspB),
        .ClearReq(ClearReq), .ClearDone(ClearDone),
        .RF_Aaddr(RF_Aaddr), .RF_Baddr(RF_Baddr), .RF_Caddr(RF_Caddr),
        .RF_C(RF_C), .RF_Load(RF_Load), .RF_Clear(RF_Clear),
        .RF_A(RF_A), .RF_B(RF_B)
    );

    // Register file: synchronous active-low clear, registered read-before-write.
    always @(posedge Clk) begin
        if (!RF_Clear) begin
            for (int i = 0; i < 16; i++) mem[i] <= 16'h0;
            RF_A <= 16'h0;
            RF_B <= 16'h0;
        end else begin
            RF_A <= mem[RF_Aaddr];
            RF_B <= mem[RF_Baddr];
            if (RF_Load) mem[RF_Caddr] <= RF_C;
        end
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic step(input logic [1:0] eg, input bit push);
        @(negedge Clk);
        chk("grant", 32'(ReqReady), 32'(eg));
        for (int i = 0; i < 2; i++)
            if (push && ReqReady[i] && v[i])
                q.push_back('{i, ea[i], eb[i]});
        @(posedge Clk);
        #1;
    endtask

    task automatic setr(input int i, input logic w, input logic [3:0] a,
                        input logic [3:0] b, input logic [3:0] c,
                        input logic [15:0] d, input logic [15:0] xa,
                        input logic [15:0] xb);
        we[i] = w; ta[i] = a; tb[i] = b; tc[i] = c;
        td[i] = d; ea[i] = xa; eb[i] = xb;
    endtask

    // Response monitor: pops the scoreboard on every response strobe.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            if (RspValid != 2'b00) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got %0h expected none", RspValid);
                end else begin
                    e = q.pop_front();
                    chk("rsp_idx", 32'(RspValid), 32'(1) << e.idx);
                    chk("rspA", 32'(RspA), 32'(e.a));
                    chk("rspB", 32'(RspB), 32'(e.b));
                end
            end
        end
    end

    initial begin
        v = 2'b11;
        ClearReq = 1'b0;
        setr(0, 1'b0, 4'd0, 4'd0, 4'd0, 16'h0, 16'h0, 16'h0);
        setr(1, 1'b0, 4'd0, 4'd0, 4'd0, 16'h0, 16'h0, 16'h0);

        repeat (2) @(posedge Clk);
        @(negedge Clk);
        chk("rst_load", 32'(RF_Load), 0);
        chk("rst_clear", 32'(RF_Clear), 0);
        chk("rst_ready", 32'(ReqReady), 0);
        chk("rst_rspv", 32'(RspValid), 0);
        chk("rst_done", 32'(ClearDone), 0);
        chk("rst_rf", {RF_Aaddr, RF_Baddr, RF_Caddr, RF_C[3:0]}, 0);
        @(posedge Clk);
        #1;
        Reset = 1'b0;

        // CLR then DONE after reset release.
        setr(0, 1'b1, 4'd0, 4'd0, 4'd3, 16'hA5A5, 16'h0, 16'h0);
        setr(1, 1'b0, 4'd3, 4'd0, 4'd7, 16'hFFFF, 16'hA5A5, 16'h0);
        chk("clr_clear", 32'(RF_Clear), 0);
        chk("clr_done", 32'(ClearDone), 0);
        step(2'b00, 1);
        chk("done_pulse", 32'(ClearDone), 1);
        chk("done_clear", 32'(RF_Clear), 1);
        step(2'b00, 1);
        chk("done_once", 32'(ClearDone), 0);
        step(2'b01, 1);
        chk("wr_caddr", 32'(RF_Caddr), 3);
        chk("wr_c", 32'(RF_C), 32'hA5A5);
        chk("wr_load", 32'(RF_Load), 1);
        v = 2'b10;
        step(2'b10, 1);
        chk("ro_caddr", 32'(RF_Caddr), 15);
        chk("ro_c", 32'(RF_C), 0);
        v = 2'b00;

        // Both requesters streaming: grants alternate.
        setr(0, 1'b1, 4'd3, 4'd2, 4'd1, 16'h1111, 16'hA5A5, 16'h0);
        setr(1, 1'b1, 4'd1, 4'd4, 4'd4, 16'h4444, 16'h1111, 16'h0);
        v = 2'b11;
        step(2'b01, 1);
        step(2'b10, 1);
        eb[1] = 16'h4444;
        step(2'b01, 1);
        step(2'b10, 1);
        step(2'b01, 1);
        step(2'b10, 1);
        v = 2'b00;
        step(2'b00, 1);

        // Read-only transaction goes to the sink register.
        setr(0, 1'b0, 4'd3, 4'd4, 4'd9, 16'hBEEF, 16'hA5A5, 16'h4444);
        v = 2'b01;
        step(2'b01, 1);
        chk("ro2_caddr", 32'(RF_Caddr), 15);
        chk("ro2_c", 32'(RF_C), 0);
        chk("ro2_load", 32'(RF_Load), 1);
        v = 2'b00;
        step(2'b00, 1);
        chk("idle_load", 32'(RF_Load), 0);

        // Same-register hazard, then back-to-back visibility.
        setr(1, 1'b1, 4'd5, 4'd4, 4'd5, 16'h1234, 16'h0, 16'h4444);
        v = 2'b10;
        step(2'b10, 1);
        setr(0, 1'b0, 4'd5, 4'd9, 4'd0, 16'h0, 16'h1234, 16'h0);
        v = 2'b01;
        step(2'b01, 1);

        // Clear while req0 streams writes.
        setr(0, 1'b1, 4'd3, 4'd5, 4'd6, 16'h6666, 16'hA5A5, 16'h1234);
        step(2'b01, 1);
        ClearReq = 1'b1;
        step(2'b00, 1);
        ClearReq = 1'b0;
        chk("creq_clear", 32'(RF_Clear), 0);
        chk("creq_done", 32'(ClearDone), 0);
        step(2'b00, 1);
        chk("creq_pulse", 32'(ClearDone), 1);
        chk("creq_clear1", 32'(RF_Clear), 1);
        setr(0, 1'b0, 4'd0, 4'd1, 4'd0, 16'h0, 16'h0, 16'h0);
        step(2'b00, 1);
        for (int k = 0; k < 8; k++) begin
            ta[0] = 4'(2 * k);
            tb[0] = 4'(2 * k + 1);
            step(2'b01, 1);
        end
        v = 2'b00;
        repeat (3) step(2'b00, 1);

        // Reset one cycle after a grant flushes it and resets the pointer.
        setr(1, 1'b0, 4'd3, 4'd0, 4'd0, 16'h0, 16'h0, 16'h0);
        v = 2'b10;
        step(2'b10, 0);
        Reset = 1'b1;
        v = 2'b11;
        step(2'b00, 0);
        chk("flush_rsp0", 32'(RspValid), 0);
        step(2'b00, 0);
        chk("flush_rsp1", 32'(RspValid), 0);
        Reset = 1'b0;
        setr(0, 1'b0, 4'd3, 4'd6, 4'd0, 16'h0, 16'h0, 16'h0);
        setr(1, 1'b0, 4'd4, 4'd1, 4'd0, 16'h0, 16'h0, 16'h0);
        step(2'b00, 1);
        chk("rst2_pulse", 32'(ClearDone), 1);
        step(2'b00, 1);
        step(2'b01, 1);
        step(2'b10, 1);
        v = 2'b00;
        repeat (4) step(2'b00, 1);
        chk("queue_empty", 32'(q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
